// File: rtl/vx_ibuffer_sched.sv
// Issue-side scheduler for the per-warp instruction buffer: occupancy tracking,
// enqueue gating and greedy-then-round-robin warp selection with starvation override.

module vx_ibuffer_sched_chk (
    input  logic clk,
    input  logic reset,
    input  logic issue_fire,
    input  logic issue_cnt_zero
);

    // Firing an offer on an empty warp would underflow its count.
    a_no_empty_issue: assert property (@(posedge clk) disable iff (reset)
        !(issue_fire && issue_cnt_zero));

endmodule

module vx_ibuffer_sched #(
    parameter int NUM_WARPS    = 4,
    parameter int IBUF_SIZE    = 2,
    parameter int STARVE_LIMIT = 7,
    localparam int NW_BITS     = $clog2(NUM_WARPS),
    localparam int CNTW        = $clog2(IBUF_SIZE + 1),
    localparam int AGEW        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_valid,
    input  logic [NW_BITS-1:0] enq_wid,
    output logic               enq_ready,
    input  logic [NUM_WARPS-1:0] stall_mask,
    output logic               issue_valid,
    output logic [NW_BITS-1:0] issue_wid,
    input  logic               issue_ready,
    output logic [NUM_WARPS-1:0] nonempty,
    output logic               starve_event
);

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(IBUF_SIZE);
    localparam logic [AGEW-1:0] AGE_ZERO = {AGEW{1'b0}};
    localparam logic [AGEW-1:0] AGE_ONE  = AGEW'(1);
    localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(STARVE_LIMIT);

    logic [CNTW-1:0]      cnt_r      [NUM_WARPS];
    logic [CNTW-1:0]      cnt_next_s [NUM_WARPS];
    logic [AGEW-1:0]      age_r      [NUM_WARPS];
    logic [AGEW-1:0]      age_next_s [NUM_WARPS];
    logic [NW_BITS-1:0]   last_r;
    logic                 issue_valid_r;
    logic [NW_BITS-1:0]   issue_wid_r;
    logic [NUM_WARPS-1:0] nonempty_r;
    logic                 starve_event_r;

    logic                 enq_fire_s;
    logic                 issue_fire_s;
    logic [NUM_WARPS-1:0] enq_hit_s;
    logic [NUM_WARPS-1:0] deq_hit_s;
    logic [NUM_WARPS-1:0] elig_s;
    logic                 load_s;
    logic                 any_elig_s;
    logic                 starve_hit_s;
    logic [NW_BITS-1:0]   starve_wid_s;
    logic [NW_BITS-1:0]   rr_idx_s;
    logic [NW_BITS-1:0]   rr_wid_s;
    logic [NW_BITS-1:0]   sel_s;
    logic [NUM_WARPS-1:0] grant_s;
    logic [NUM_WARPS-1:0] offered_s;

    assign enq_ready    = (cnt_r[enq_wid] != CNT_FULL);
    assign issue_valid  = issue_valid_r;
    assign issue_wid    = issue_wid_r;
    assign nonempty     = nonempty_r;
    assign starve_event = starve_event_r;

    // Next occupancy per warp and the resulting eligibility.
    always_comb begin
        enq_fire_s   = enq_valid && enq_ready;
        issue_fire_s = issue_valid_r && issue_ready;
        for (int w = 0; w < NUM_WARPS; w++) begin
            enq_hit_s[w] = enq_fire_s && (enq_wid == NW_BITS'(w));
            deq_hit_s[w] = issue_fire_s && (issue_wid_r == NW_BITS'(w));
            case ({enq_hit_s[w], deq_hit_s[w]})
                2'b10:   cnt_next_s[w] = cnt_r[w] + CNT_ONE;
                2'b01:   cnt_next_s[w] = cnt_r[w] - CNT_ONE;
                default: cnt_next_s[w] = cnt_r[w];
            endcase
            elig_s[w] = (cnt_next_s[w] != CNT_ZERO) && !stall_mask[w];
        end
    end

    // Warp selection: starving warp first, then the last grant, then round-robin.
    always_comb begin
        load_s       = !issue_valid_r || issue_fire_s;
        any_elig_s   = |elig_s;
        starve_hit_s = 1'b0;
        starve_wid_s = {NW_BITS{1'b0}};
        // Descending scans so the lowest index / nearest RR distance wins.
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            starve_wid_s = (elig_s[w] && (age_r[w] == AGE_MAX)) ? NW_BITS'(w) : starve_wid_s;
            starve_hit_s = starve_hit_s || (elig_s[w] && (age_r[w] == AGE_MAX));
        end
        rr_idx_s = last_r;
        rr_wid_s = last_r;
        for (int k = NUM_WARPS - 1; k >= 1; k--) begin
            rr_idx_s = last_r + NW_BITS'(k);
            rr_wid_s = elig_s[rr_idx_s] ? rr_idx_s : rr_wid_s;
        end
        if (starve_hit_s) begin
            sel_s = starve_wid_s;
        end else if (elig_s[last_r]) begin
            sel_s = last_r;
        end else begin
            sel_s = rr_wid_s;
        end
    end

    // Age counts cycles a warp is eligible but not on offer.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            grant_s[w]   = load_s && any_elig_s && (sel_s == NW_BITS'(w));
            offered_s[w] = issue_valid_r && (issue_wid_r == NW_BITS'(w));
            if (grant_s[w] || !elig_s[w]) begin
                age_next_s[w] = AGE_ZERO;
            end else if (!offered_s[w]) begin
                age_next_s[w] = (age_r[w] == AGE_MAX) ? AGE_MAX : age_r[w] + AGE_ONE;
            end else begin
                age_next_s[w] = age_r[w];
            end
        end
    end

    // State registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= CNT_ZERO;
                age_r[w] <= AGE_ZERO;
            end
            last_r         <= NW_BITS'(NUM_WARPS - 1);
            issue_valid_r  <= 1'b0;
            issue_wid_r    <= {NW_BITS{1'b0}};
            nonempty_r     <= {NUM_WARPS{1'b0}};
            starve_event_r <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w]      <= cnt_next_s[w];
                age_r[w]      <= age_next_s[w];
                nonempty_r[w] <= (cnt_next_s[w] != CNT_ZERO);
            end
            if (load_s) begin
                issue_valid_r  <= any_elig_s;
                starve_event_r <= any_elig_s && starve_hit_s;
            end else begin
                starve_event_r <= 1'b0;
            end
            if (load_s && any_elig_s) begin
                issue_wid_r <= sel_s;
                last_r      <= sel_s;
            end else begin
                issue_wid_r <= issue_wid_r;
                last_r      <= last_r;
            end
        end
    end

    vx_ibuffer_sched_chk u_chk (
        .clk            (clk),
        .reset          (reset),
        .issue_fire     (issue_fire_s),
        .issue_cnt_zero (cnt_r[issue_wid_r] == CNT_ZERO)
    );

endmodule
